// File: rtl/uart_frame_rx_if.sv
// uart_frame_rx_if: byte strobe input and frame/status outputs.
// IMG_BYTES must match the receiver it is bound to.
interface uart_frame_rx_if #(
   parameter int IMG_BYTES = 784
);
   localparam int DCW = $clog2(IMG_BYTES);

   logic                   data_rdy;
   logic [7:0]             uart_byte;
   logic                   start;
   logic                   train;
   logic                   resend;
   logic                   timeout;
   logic                   frame_err;
   logic [7:0]             label;
   logic [IMG_BYTES*8-1:0] image;
   logic [2:0]             cs_out;
   logic [DCW-1:0]         data_count;

   modport slave (
      input  data_rdy, uart_byte,
      output start, train, resend, timeout, frame_err,
      output label, image, cs_out, data_count
   );

   modport master (
      output data_rdy, uart_byte,
      input  start, train, resend, timeout, frame_err,
      input  label, image, cs_out, data_count
   );
endinterface

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: FF / mode / label / pixels / checksum frame receiver.
// Define UART_CHECKSUM_EN to enable checksum compare and resend/retry.
module uart_frame_rx #(
   parameter int IMG_BYTES   = 784,
   parameter int TIMEOUT_CYC = 2047,
   parameter int MAX_RETRY   = 1
) (
   input  logic           uart_sampling_clk,
   input  logic           rst_n,
   uart_frame_rx_if.slave bus
);
   localparam int IW  = IMG_BYTES * 8;
   localparam int DCW = $clog2(IMG_BYTES);
   localparam int GW  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [DCW-1:0] LAST = DCW'(IMG_BYTES - 1);
   localparam logic [GW-1:0]  TMO  = GW'(TIMEOUT_CYC);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MODE  = 3'd1,
      S_LABEL = 3'd2,
      S_DATA  = 3'd3,
      S_CHECK = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [DCW-1:0] dcnt_q, dcnt_d;
   logic [GW-1:0]  gap_q, gap_d, gap_inc;
   logic [IW-1:0]  shadow_q, shadow_d;
   logic [IW-1:0]  image_q, image_d;
   logic [7:0]     plabel_q, plabel_d;
   logic [7:0]     label_q, label_d;
   logic           ptrain_q, ptrain_d;
   logic           train_q, train_d;
   logic           start_q, start_d;
   logic           timeout_q, timeout_d;
   logic           accept;
   logic           rdy;
   logic [7:0]     din;

`ifdef UART_CHECKSUM_EN
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

   logic [7:0]    chk_q, chk_d;
   logic [RW-1:0] retry_q, retry_d;
   logic          resend_q, resend_d;
   logic          ferr_q, ferr_d;

   // one's-complement add: wrap the carry back into bit 0
   function automatic logic [7:0] add1c(input logic [7:0] a,
                                        input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[7:0] + {7'd0, s[8]};
   endfunction
`endif

   assign rdy = bus.data_rdy;
   assign din = bus.uart_byte;

   always_comb begin
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      gap_d     = gap_q;
      shadow_d  = shadow_q;
      image_d   = image_q;
      plabel_d  = plabel_q;
      label_d   = label_q;
      ptrain_d  = ptrain_q;
      train_d   = train_q;
      start_d   = 1'b0;
      timeout_d = 1'b0;
      accept    = 1'b0;
      gap_inc   = gap_q + GW'(1);
`ifdef UART_CHECKSUM_EN
      chk_d    = chk_q;
      retry_d  = retry_q;
      resend_d = 1'b0;
      ferr_d   = 1'b0;
`endif
      if (state_q != S_IDLE) begin
         gap_d = rdy ? '0 : gap_inc;
      end
      unique case (state_q)
         S_IDLE: begin
            if (rdy && din == 8'hFF) begin
               state_d = S_MODE;
            end
         end
         S_MODE: begin
            if (rdy) begin
               if (din == 8'hF0) begin
                  ptrain_d = 1'b1;
                  state_d  = S_LABEL;
               end else if (din == 8'h0F) begin
                  ptrain_d = 1'b0;
                  state_d  = S_LABEL;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_LABEL: begin
            if (rdy) begin
               plabel_d = din;
`ifdef UART_CHECKSUM_EN
               chk_d    = din;
`endif
               state_d  = S_DATA;
            end
         end
         S_DATA: begin
            if (rdy) begin
               shadow_d = {din, shadow_q[IW-1:8]};
               dcnt_d   = dcnt_q + DCW'(1);
`ifdef UART_CHECKSUM_EN
               chk_d    = add1c(chk_q, din);
`endif
               if (dcnt_q == LAST) begin
                  state_d = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            if (rdy) begin
               state_d = S_IDLE;
`ifdef UART_CHECKSUM_EN
               accept = (din == chk_q);
`else
               accept = 1'b1;
`endif
               if (accept) begin
                  image_d = shadow_q;
                  label_d = plabel_q;
                  train_d = ptrain_q;
                  start_d = 1'b1;
`ifdef UART_CHECKSUM_EN
                  retry_d = '0;
               end else if (retry_q < RMAX) begin
                  resend_d = 1'b1;
                  retry_d  = retry_q + RW'(1);
               end else begin
                  ferr_d  = 1'b1;
                  retry_d = '0;
`endif
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // a byte landing on the deadline cycle keeps the frame alive
      if (state_q != S_IDLE && !rdy && gap_inc == TMO) begin
         timeout_d = 1'b1;
         state_d   = S_IDLE;
      end
      if (state_d == S_IDLE) begin
         dcnt_d = '0;
         gap_d  = '0;
`ifdef UART_CHECKSUM_EN
         chk_d  = '0;
`endif
      end
   end

   always_ff @(posedge uart_sampling_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         dcnt_q    <= '0;
         gap_q     <= '0;
         shadow_q  <= '0;
         image_q   <= '0;
         plabel_q  <= '0;
         label_q   <= '0;
         ptrain_q  <= 1'b0;
         train_q   <= 1'b0;
         start_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dcnt_q    <= dcnt_d;
         gap_q     <= gap_d;
         shadow_q  <= shadow_d;
         image_q   <= image_d;
         plabel_q  <= plabel_d;
         label_q   <= label_d;
         ptrain_q  <= ptrain_d;
         train_q   <= train_d;
         start_q   <= start_d;
         timeout_q <= timeout_d;
      end
   end

`ifdef UART_CHECKSUM_EN
   always_ff @(posedge uart_sampling_clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_q    <= '0;
         retry_q  <= '0;
         resend_q <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         chk_q    <= chk_d;
         retry_q  <= retry_d;
         resend_q <= resend_d;
         ferr_q   <= ferr_d;
      end
   end

   assign bus.resend    = resend_q;
   assign bus.frame_err = ferr_q;
`else
   assign bus.resend    = 1'b0;
   assign bus.frame_err = 1'b0;
   // retry depth only matters when checksums can reject a frame
   if (MAX_RETRY < 0) begin : g_no_retry
   end
`endif

   assign bus.start      = start_q;
   assign bus.timeout    = timeout_q;
   assign bus.train      = train_q;
   assign bus.label      = label_q;
   assign bus.image      = image_q;
   assign bus.cs_out     = state_q;
   assign bus.data_count = dcnt_q;
endmodule
